// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Optional watchdog between device clock edges is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 120,
  parameter int unsigned TIMEOUT_CYCLES = 15000
) (
  input  logic       i_clk_1M,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_done,
  output logic       o_error,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL
  } state_t;

  localparam logic [13:0] INHIBIT_LAST = 14'(INHIBIT_CYCLES - 1);

  // Both counts must fit the 14-bit cycle counter.
  if (INHIBIT_CYCLES < 1 || INHIBIT_CYCLES > 16383 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16383) begin : g_bad_params
    $error("ps2_host_tx: cycle parameters must be in 1..16383");
  end

  logic [1:0] clk_sync, dat_sync;
  logic       clk_prev;
  logic       clk_s, dat_s, fall;

  state_t      state_q, state_n;
  logic [7:0]  data_q, data_n;
  logic        parity_q, parity_n;
  logic [3:0]  bit_q, bit_n;
  logic [13:0] cyc_q, cyc_n, cyc_inc;
  logic        clk_oe_q, clk_oe_n;
  logic        dat_oe_q, dat_oe_n;
  logic        done_q, done_n;
  logic        error_q, error_n;

  // Synchronisers idle high so reset never fakes a falling edge.
  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync <= {clk_sync[0], i_ps2_clk};
      dat_sync <= {dat_sync[0], i_ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign clk_s   = clk_sync[1];
  assign dat_s   = dat_sync[1];
  assign fall    = clk_prev & ~clk_s;
  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 14'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_n  = state_q;
    data_n   = data_q;
    parity_n = parity_q;
    bit_n    = bit_q;
    cyc_n    = cyc_q;
    clk_oe_n = clk_oe_q;
    dat_oe_n = dat_oe_q;
    done_n   = 1'b0;
    error_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cyc_n    = '0;
        bit_n    = '0;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        if (i_valid) begin
          data_n   = i_data;
          parity_n = ~^i_data;
          clk_oe_n = 1'b1;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: begin
        cyc_n = cyc_inc;
        if (cyc_q == INHIBIT_LAST) begin
          dat_oe_n = 1'b1;
          state_n  = REQ;
        end
      end
      REQ: begin
        clk_oe_n = 1'b0;
        bit_n    = '0;
        cyc_n    = '0;
        state_n  = SEND;
      end
      SEND: begin
        // bit_q counts edges already seen, so edge n drives data[n-1].
        if (fall) begin
          bit_n = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            dat_oe_n = ~data_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            dat_oe_n = ~parity_q;
          end else begin
            dat_oe_n = 1'b0;
            state_n  = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          if (!dat_s) begin
            state_n = WAIT_REL;
          end else begin
            error_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_REL: begin
        if (clk_s && dat_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state_q inside {SEND, ACK, WAIT_REL}) begin
      if (fall) begin
        cyc_n = '0;
      end else if (cyc_q >= 14'(TIMEOUT_CYCLES - 1)) begin
        state_n  = IDLE;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        done_n   = 1'b0;
        error_n  = 1'b1;
        cyc_n    = '0;
      end else begin
        cyc_n = cyc_inc;
      end
    end
`endif
  end

  // Line enables are flops with async reset, so reset releases the pads without a clock.
  always_ff @(posedge i_clk_1M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      parity_q <= 1'b0;
      bit_q    <= '0;
      cyc_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      data_q   <= data_n;
      parity_q <= parity_n;
      bit_q    <= bit_n;
      cyc_q    <= cyc_n;
      clk_oe_q <= clk_oe_n;
      dat_oe_q <= dat_oe_n;
      done_q   <= done_n;
      error_q  <= error_n;
    end
  end

  assign o_ready      = (state_q == IDLE);
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_ps2_clk_oe = clk_oe_q;
  assign o_ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a 12.5 kHz PS/2 device model on open-drain lines.
// Timeout scenario behaviour follows PS2_TX_TIMEOUT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 120;
  localparam int TO  = 15000;
  localparam int HALF_PS2 = 40;  // 12.5 kHz device clock = 80 system cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, done, error, clk_oe, dat_oe;
  logic       ps2_clk, ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk = ~(clk_oe | dev_clk_low);
  assign ps2_dat = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk_1M     (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_done       (done),
    .o_error      (error),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_dat    (ps2_dat),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_dat_oe (dat_oe)
  );

  always #500 clk = ~clk;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int accepts = 0, last_acc = -1;
  int dones = 0, errors = 0, both = 0, bad_ready = 0, last_done = -2;
  int last_fall = 0;

  always @(posedge clk) begin
    if (valid && ready) begin
      accepts <= accepts + 1;
      last_acc <= cyc;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (done) begin
      dones = dones + 1;
      last_done = cyc;
    end
    if (error) errors = errors + 1;
    if (done && error) both = both + 1;
    if ((done || error) && !ready) bad_ready = bad_ready + 1;
  end

  task automatic accept_byte(input logic [7:0] b, input bit hold);
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    if (!hold) valid = 1'b0;
  endtask

  // Counts cycles of inhibit (clk low only) then request (clk and data low).
  task automatic measure_inhibit(output int inh, output int req);
    inh = 0;
    req = 0;
    while (clk_oe && !dat_oe && inh < 1000) begin
      inh++;
      @(negedge clk);
    end
    while (clk_oe && dat_oe && req < 1000) begin
      req++;
      @(negedge clk);
    end
  endtask

  // Device clocks the frame; bits[n-1] is the line level sampled before rising edge n.
  task automatic dev_frame(input bit ack, input int stop_at, input bit hold_low,
                           output logic start_bit, output logic [9:0] bits);
    bits = '0;
    repeat (10) @(negedge clk);
    start_bit = ps2_dat;
    for (int n = 1; n <= 11; n++) begin
      if (n == 11) begin
        dev_dat_low = ack;
        repeat (10) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      last_fall = cyc;
      if (hold_low && n == stop_at) begin
        repeat (10) @(negedge clk);
        return;
      end
      repeat (HALF_PS2) @(negedge clk);
      if (n <= 10) bits[n-1] = ps2_dat;
      dev_clk_low = 1'b0;
      if (n == 11) dev_dat_low = 1'b0;
      repeat (HALF_PS2) @(negedge clk);
      if (n == stop_at) return;
    end
  endtask

  task automatic test_reset;
    #10 rst_n = 1'b0;
    #10;
    total++; if (clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", clk_oe); else passed++;
    total++; if (dat_oe !== 1'b0) $display("FAIL reset_dat_oe: got %b want 0", dat_oe); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Full frame with device ACK; checks handshake, inhibit timing, frame bits, one done.
  task automatic send_frame(input string nm, input logic [7:0] b, input logic [9:0] exp_bits);
    int inh, req, d0, e0;
    logic sb;
    logic [9:0] bits;
    d0 = dones;
    e0 = errors;
    accept_byte(b, 1'b0);
    total++; if (ready !== 1'b0 || clk_oe !== 1'b1)
      $display("FAIL %s_accept: ready=%b clk_oe=%b want ready=0 clk_oe=1", nm, ready, clk_oe); else passed++;
    measure_inhibit(inh, req);
    total++; if (inh !== INH) $display("FAIL %s_inhibit_len: got %0d want %0d", nm, inh, INH); else passed++;
    total++; if (req !== 1) $display("FAIL %s_req_len: got %0d want 1", nm, req); else passed++;
    total++; if (clk_oe !== 1'b0 || dat_oe !== 1'b1)
      $display("FAIL %s_release: clk_oe=%b dat_oe=%b want 0,1", nm, clk_oe, dat_oe); else passed++;
    dev_frame(1'b1, 0, 1'b0, sb, bits);
    repeat (10) @(negedge clk);
    total++; if (sb !== 1'b0) $display("FAIL %s_start_bit: got %b want 0", nm, sb); else passed++;
    total++; if (bits !== exp_bits) $display("FAIL %s_frame_bits: got %h want %h", nm, bits, exp_bits); else passed++;
    total++; if (dones - d0 !== 1) $display("FAIL %s_done_count: got %0d want 1", nm, dones - d0); else passed++;
    total++; if (errors - e0 !== 0) $display("FAIL %s_error_count: got %0d want 0", nm, errors - e0); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL %s_ready_after: got %b want 1", nm, ready); else passed++;
  endtask

  // 8'hED LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1.
  task automatic test_send_ed;
    send_frame("ed", 8'hED, 10'h3ED);
  endtask

  // All-zero byte: parity bit is 1, so the line is released on edge 9.
  task automatic test_send_zero;
    send_frame("zero", 8'h00, 10'h300);
  endtask

  task automatic test_nack;
    int inh, req, d0, e0;
    logic sb;
    logic [9:0] bits;
    d0 = dones;
    e0 = errors;
    accept_byte(8'hA5, 1'b0);
    measure_inhibit(inh, req);
    dev_frame(1'b0, 0, 1'b0, sb, bits);
    repeat (10) @(negedge clk);
    total++; if (bits !== 10'h3A5) $display("FAIL nack_frame_bits: got %h want 3a5", bits); else passed++;
    total++; if (errors - e0 !== 1) $display("FAIL nack_error_count: got %0d want 1", errors - e0); else passed++;
    total++; if (dones - d0 !== 0) $display("FAIL nack_done_count: got %0d want 0", dones - d0); else passed++;
    total++; if (ready !== 1'b1 || dat_oe !== 1'b0)
      $display("FAIL nack_idle: ready=%b dat_oe=%b want 1,0", ready, dat_oe); else passed++;
  endtask

  task automatic test_reset_mid;
    int inh, req;
    logic sb;
    logic [9:0] bits;
    accept_byte(8'hA5, 1'b0);
    measure_inhibit(inh, req);
    dev_frame(1'b1, 5, 1'b1, sb, bits);
    // A5 bit 4 is 0, so the host is pulling data low during bit 5.
    total++; if (dat_oe !== 1'b1) $display("FAIL rstmid_bit5_driven: got %b want 1", dat_oe); else passed++;
    #200 rst_n = 1'b0;
    #1;
    total++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0)
      $display("FAIL rstmid_async_release: clk_oe=%b dat_oe=%b want 0,0", clk_oe, dat_oe); else passed++;
    dev_clk_low = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", ready); else passed++;
    // 8'hF4 has five ones, so parity is 0.
    send_frame("f4", 8'hF4, 10'h2F4);
  endtask

  task automatic test_timeout;
    int inh, req, e0, d0, waited;
    logic sb;
    logic [9:0] bits;
    e0 = errors;
    d0 = dones;
    accept_byte(8'h37, 1'b0);
    measure_inhibit(inh, req);
    dev_frame(1'b1, 4, 1'b0, sb, bits);
    // 8'h37 bit 3 is 0, so data is still held low after edge 4.
    total++; if (dat_oe !== 1'b1) $display("FAIL timeout_bit4_driven: got %b want 1", dat_oe); else passed++;
`ifdef PS2_TX_TIMEOUT_EN
    waited = 0;
    while (!error && waited < TO + 2000) begin
      @(negedge clk);
      waited++;
    end
    // Three cycles of synchroniser and edge-detect latency precede the detected edge.
    total++; if (cyc - last_fall !== TO + 3)
      $display("FAIL timeout_latency: got %0d want %0d", cyc - last_fall, TO + 3); else passed++;
    total++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0 || ready !== 1'b1)
      $display("FAIL timeout_release: clk_oe=%b dat_oe=%b ready=%b want 0,0,1", clk_oe, dat_oe, ready); else passed++;
    @(negedge clk);
    total++; if (errors - e0 !== 1 || dones - d0 !== 0)
      $display("FAIL timeout_pulses: errors=%0d dones=%0d want 1,0", errors - e0, dones - d0); else passed++;
`else
    waited = 0;
    repeat (TO + 1000) begin
      @(negedge clk);
      waited++;
    end
    total++; if (errors - e0 !== 0) $display("FAIL notimeout_error: got %0d want 0", errors - e0); else passed++;
    total++; if (ready !== 1'b0 || dat_oe !== 1'b1)
      $display("FAIL notimeout_waiting: ready=%b dat_oe=%b want 0,1", ready, dat_oe); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
  endtask

  task automatic test_back_to_back;
    int inh, req, a0, d0, g;
    logic sb;
    logic [9:0] bits;
    a0 = accepts;
    d0 = dones;
    accept_byte(8'hED, 1'b1);
    measure_inhibit(inh, req);
    dev_frame(1'b1, 0, 1'b0, sb, bits);
    repeat (10) @(negedge clk);
    total++; if (accepts - a0 !== 2) $display("FAIL b2b_accepts_first: got %0d want 2", accepts - a0); else passed++;
    total++; if (last_acc !== last_done)
      $display("FAIL b2b_accept_cycle: accept=%0d done=%0d want equal", last_acc, last_done); else passed++;
    total++; if (ready !== 1'b0 || clk_oe !== 1'b1)
      $display("FAIL b2b_second_inhibit: ready=%b clk_oe=%b want 0,1", ready, clk_oe); else passed++;
    valid = 1'b0;
    g = 0;
    while (clk_oe && g < 1000) begin
      @(negedge clk);
      g++;
    end
    total++; if (clk_oe !== 1'b0) $display("FAIL b2b_release_timeout: clk_oe=%b want 0", clk_oe); else passed++;
    dev_frame(1'b1, 0, 1'b0, sb, bits);
    repeat (10) @(negedge clk);
    total++; if (bits !== 10'h3ED) $display("FAIL b2b_frame_bits: got %h want 3ed", bits); else passed++;
    total++; if (accepts - a0 !== 2 || dones - d0 !== 2)
      $display("FAIL b2b_counts: accepts=%0d dones=%0d want 2,2", accepts - a0, dones - d0); else passed++;
  endtask

  task automatic test_invariants;
    total++; if (both !== 0) $display("FAIL done_error_overlap: got %0d want 0", both); else passed++;
    total++; if (bad_ready !== 0) $display("FAIL ready_with_pulse: got %0d want 0", bad_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_zero();
    test_nack();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
